markov_predictor: RTL and testbench

- Parametrised successor to the team's first-order rock-paper-scissors Markov learner.
- Keeps a transition-count table indexed by the last ORDER opponent moves and predicts the opponent's next move. It then outputs the move that beats that prediction.
- Adds the following: selectable history order, saturating counts with row halving, an explicit table-clear sweep, a valid/ready move handshake, and deterministic rotating tie-break.
- Sits between the player-input front end and the score/display logic.

---
 rtl/rps_pkg.sv | 72 +++++++
 rtl/mod3_rotor.sv | 20 ++
 rtl/markov_predictor.sv | 175 +++++++++++++++++
 tb/tb_markov_predictor.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared rock-paper-scissors definitions: move codes, FSM states and the
// helpers used to turn a row of transition counts into a prediction.
package rps_pkg;

  typedef logic [1:0] move_t;

  localparam move_t MOVE_ROCK     = 2'd0;
  localparam move_t MOVE_PAPER    = 2'd1;
  localparam move_t MOVE_SCISSORS = 2'd2;
  localparam move_t MOVE_ILLEGAL  = 2'd3;

  // Counters are widened to this before argmax so the helper is width-agnostic.
  localparam int CNT_MAX_W = 16;

  typedef logic [2:0][CNT_MAX_W-1:0] counts_t;

  typedef struct packed {
    move_t idx;
    logic  uniq;
  } argmax_t;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DECIDE = 2'd3
  } state_t;

  function automatic move_t beats(move_t m);
    case (m)
      MOVE_ROCK:     return MOVE_PAPER;
      MOVE_PAPER:    return MOVE_SCISSORS;
      MOVE_SCISSORS: return MOVE_ROCK;
      default:       return MOVE_PAPER;
    endcase
  endfunction

  // First maximum found scanning start, start+1, start+2 (mod 3).
  function automatic argmax_t argmax3(counts_t counts, move_t start);
    argmax_t              res;
    logic [CNT_MAX_W-1:0] mx;
    logic [CNT_MAX_W-1:0] cur;
    move_t                idx;
    logic                 found;
    logic [1:0]           n_eq;
    mx       = (counts[1] > counts[0]) ? counts[1] : counts[0];
    mx       = (counts[2] > mx) ? counts[2] : mx;
    idx      = start;
    found    = 1'b0;
    n_eq     = 2'd0;
    res.idx  = start;
    res.uniq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      case (idx)
        2'd0:    cur = counts[0];
        2'd1:    cur = counts[1];
        default: cur = counts[2];
      endcase
      if (cur == mx) begin
        n_eq = n_eq + 2'd1;
        if (!found) begin
          res.idx = idx;
          found   = 1'b1;
        end
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    res.uniq = (n_eq == 2'd1);
    return res;
  endfunction

endpackage

// File: rtl/mod3_rotor.sv
// Free-running 0->1->2->0 counter; seeds warm-up guesses and the tie-break
// scan start.
module mod3_rotor (
  input  logic       clock,
  input  logic       reset,
  output logic [1:0] value
);

  // advance every cycle, never reaching 3
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= 2'd0;
    end else if (value == 2'd2) begin
      value <= 2'd0;
    end else begin
      value <= value + 2'd1;
    end
  end

endmodule

// File: rtl/markov_predictor.sv
// Order-N Markov predictor for rock-paper-scissors: learns opponent move
// transitions in a saturating count table and plays the move that beats the
// most likely next opponent move.
module markov_predictor
  import rps_pkg::*;
#(
  parameter int ORDER = 1,
  parameter int CNT_W = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       move_valid,
  input  logic [1:0] move_in,
  output logic       move_ready,
  output logic       choice_valid,
  output logic [1:0] choice,
  output logic [1:0] predicted,
  output logic       confident,
  output logic       bad_move
);

  localparam int ROWS = 4 ** ORDER;
  localparam int HW   = 2 * ORDER;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [HW-1:0]           sweep_r;
  logic [HW-1:0]           history_r;
  logic [HW-1:0]           hist_nxt_s;
  logic [1:0]              hist_cnt_r;
  logic [1:0]              hist_cnt_nxt_s;
  move_t                   move_r;
  logic [1:0]              rotor_s;
  logic [1:0]              rotor_nxt_s;
  logic                    accept_s;
  logic                    upd_apply_s;
  logic                    sat_s;
  logic [2:0][CNT_W-1:0]   table_r [ROWS];
  logic [2:0][CNT_W-1:0]   cur_row_s;
  logic [2:0][CNT_W-1:0]   upd_row_s;
  logic [2:0][CNT_W-1:0]   dec_row_s;
  counts_t                 dec_counts_s;
  argmax_t                 am_s;
  move_t                   pred_s;
  logic                    conf_s;

  mod3_rotor u_rotor (
    .clock (clock),
    .reset (reset),
    .value (rotor_s)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic; clear wins over a simultaneous move
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR:  state_nxt_s = (sweep_r == HW'(ROWS - 1)) ? ST_IDLE : ST_CLEAR;
      ST_IDLE: begin
        if (clear) begin
          state_nxt_s = ST_CLEAR;
        end else if (move_valid && (move_in != MOVE_ILLEGAL)) begin
          state_nxt_s = ST_UPDATE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_UPDATE: state_nxt_s = ST_DECIDE;
      ST_DECIDE: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_CLEAR;
    endcase
  end

  // handshake output decode
  always_comb begin
    move_ready = (state_r == ST_IDLE);
  end

  assign accept_s = move_valid & move_ready & ~clear;

  // row update for the current context: halve the row on saturation, then bump
  always_comb begin
    upd_apply_s = (hist_cnt_r == 2'(ORDER));
    cur_row_s   = table_r[history_r];
    sat_s       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sat_s = sat_s | ((move_r == 2'(i)) && (cur_row_s[i] == {CNT_W{1'b1}}));
    end
    upd_row_s = cur_row_s;
    for (int i = 0; i < 3; i++) begin
      upd_row_s[i] = (upd_apply_s && sat_s) ? (cur_row_s[i] >> 1) : cur_row_s[i];
      upd_row_s[i] = (upd_apply_s && (move_r == 2'(i))) ? (upd_row_s[i] + CNT_W'(1'b1))
                                                         : upd_row_s[i];
    end
  end

  // The decision is formed during UPDATE so it is registered for the DECIDE
  // cycle; when the new context row is the one being written, use the new data.
  always_comb begin
    hist_nxt_s     = HW'(history_r << 2) | HW'(move_r);
    hist_cnt_nxt_s = (hist_cnt_r == 2'(ORDER)) ? hist_cnt_r : hist_cnt_r + 2'd1;
    dec_row_s      = (hist_nxt_s == history_r) ? upd_row_s : table_r[hist_nxt_s];
    for (int i = 0; i < 3; i++) begin
      dec_counts_s[i] = CNT_MAX_W'(dec_row_s[i]);
    end
    rotor_nxt_s = (rotor_s == 2'd2) ? 2'd0 : rotor_s + 2'd1;
    am_s        = argmax3(dec_counts_s, rotor_nxt_s);
    if (hist_cnt_nxt_s < 2'(ORDER)) begin
      pred_s = rotor_nxt_s;
      conf_s = 1'b0;
    end else begin
      pred_s = am_s.idx;
      conf_s = am_s.uniq;
    end
  end

  // context, latched move and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      sweep_r      <= '0;
      history_r    <= '0;
      hist_cnt_r   <= 2'd0;
      move_r       <= MOVE_ROCK;
      choice_valid <= 1'b0;
      choice       <= 2'd0;
      predicted    <= 2'd0;
      confident    <= 1'b0;
      bad_move     <= 1'b0;
    end else begin
      choice_valid <= 1'b0;
      bad_move     <= 1'b0;
      case (state_r)
        ST_CLEAR: sweep_r <= sweep_r + HW'(1);
        ST_IDLE: begin
          if (clear) begin
            history_r  <= '0;
            hist_cnt_r <= 2'd0;
            sweep_r    <= '0;
          end else if (accept_s) begin
            move_r   <= move_in;
            bad_move <= (move_in == MOVE_ILLEGAL);
          end
        end
        ST_UPDATE: begin
          history_r    <= hist_nxt_s;
          hist_cnt_r   <= hist_cnt_nxt_s;
          choice_valid <= 1'b1;
          predicted    <= pred_s;
          choice       <= beats(pred_s);
          confident    <= conf_s;
        end
        default: sweep_r <= sweep_r;
      endcase
    end
  end

  // transition table: one row written per cycle
  always_ff @(posedge clock) begin
    if (state_r == ST_CLEAR) begin
      table_r[sweep_r] <= '0;
    end else if ((state_r == ST_UPDATE) && upd_apply_s) begin
      table_r[history_r] <= upd_row_s;
    end
  end

endmodule

// File: tb/tb_markov_predictor.sv
// Self-checking bench: three predictor instances (order 1, order 2, narrow
// counters) checked against a count-table reference model.
module tb_markov_predictor;

  typedef struct {
    bit         timeout;
    logic       cv1, rdy1, bm1, cv2, rdy2, bm2, cv3, rdy3, cf;
    logic [1:0] pr, ch;
    int         rot;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst [3];
  logic       clr [3];
  logic       mv  [3];
  logic [1:0] mi  [3];
  logic       rdy [3];
  logic       cv  [3];
  logic       bm  [3];
  logic       cf  [3];
  logic [1:0] ch  [3];
  logic [1:0] pr  [3];

  int errors = 0;
  int checks = 0;
  int cyc [3] = '{0, 0, 0};
  int ORD [3] = '{1, 2, 1};
  int CMAX[3] = '{255, 255, 3};
  int mcnt[3][64][3];
  int mhist[3];
  int mhcnt[3];

  always #5 clk = ~clk;

  markov_predictor #(.ORDER(1), .CNT_W(8)) dut_o1 (
    .clock(clk), .reset(rst[0]), .clear(clr[0]), .move_valid(mv[0]), .move_in(mi[0]),
    .move_ready(rdy[0]), .choice_valid(cv[0]), .choice(ch[0]), .predicted(pr[0]),
    .confident(cf[0]), .bad_move(bm[0]));
  markov_predictor #(.ORDER(2), .CNT_W(8)) dut_o2 (
    .clock(clk), .reset(rst[1]), .clear(clr[1]), .move_valid(mv[1]), .move_in(mi[1]),
    .move_ready(rdy[1]), .choice_valid(cv[1]), .choice(ch[1]), .predicted(pr[1]),
    .confident(cf[1]), .bad_move(bm[1]));
  markov_predictor #(.ORDER(1), .CNT_W(2)) dut_w2 (
    .clock(clk), .reset(rst[2]), .clear(clr[2]), .move_valid(mv[2]), .move_in(mi[2]),
    .move_ready(rdy[2]), .choice_valid(cv[2]), .choice(ch[2]), .predicted(pr[2]),
    .confident(cf[2]), .bad_move(bm[2]));

  // rotor reference: cycles since reset, mod 3
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) cyc[d] <= rst[d] ? 0 : (cyc[d] + 1) % 3;
  end

  function automatic void model_clear(input int d);
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 3; c++) mcnt[d][r][c] = 0;
    mhist[d] = 0;
    mhcnt[d] = 0;
  endfunction

  task automatic model_step(input int d, input int m, input int rot, output int p, output int conf);
    int rows, row, mx, n;
    rows = 4 ** ORD[d];
    if (mhcnt[d] == ORD[d]) begin
      row = mhist[d];
      if (mcnt[d][row][m] == CMAX[d])
        for (int c = 0; c < 3; c++) mcnt[d][row][c] = mcnt[d][row][c] / 2;
      mcnt[d][row][m] = mcnt[d][row][m] + 1;
    end
    mhist[d] = (mhist[d] * 4 + m) % rows;
    if (mhcnt[d] < ORD[d]) mhcnt[d] = mhcnt[d] + 1;
    if (mhcnt[d] < ORD[d]) begin
      p = rot;
      conf = 0;
    end else begin
      row = mhist[d];
      mx = 0;
      for (int c = 0; c < 3; c++) if (mcnt[d][row][c] > mx) mx = mcnt[d][row][c];
      p = -1;
      n = 0;
      for (int k = 0; k < 3; k++) begin
        if (mcnt[d][row][(rot + k) % 3] == mx) begin
          n++;
          if (p < 0) p = (rot + k) % 3;
        end
      end
      conf = (n == 1) ? 1 : 0;
    end
  endtask

  // Offer one move when ready (optionally timed so the rotor is want_rot at
  // DECIDE) and record what the DUT shows on the following cycles.
  task automatic do_move(input int d, input int m, input int want_rot, output obs_t o);
    int n = 0;
    o.timeout = 1'b0;
    while ((rdy[d] !== 1'b1 || (want_rot >= 0 && (cyc[d] + 2) % 3 != want_rot)) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) o.timeout = 1'b1;
    mv[d] = 1'b1;
    mi[d] = 2'(m);
    @(posedge clk);
    @(negedge clk);
    mv[d] = 1'b0;
    o.cv1 = cv[d]; o.rdy1 = rdy[d]; o.bm1 = bm[d];
    @(negedge clk);
    o.cv2 = cv[d]; o.rdy2 = rdy[d]; o.bm2 = bm[d];
    o.pr = pr[d]; o.ch = ch[d]; o.cf = cf[d]; o.rot = cyc[d];
    o.cv3 = 1'b0; o.rdy3 = 1'b1;
    if (m != 3) begin
      @(negedge clk);
      o.cv3 = cv[d]; o.rdy3 = rdy[d];
    end
  endtask

  task automatic test_reset(input int d);
    int n = 0;
    @(negedge clk);
    rst[d] = 1'b1; mv[d] = 1'b0; clr[d] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({rdy[d], cv[d], bm[d], cf[d], ch[d], pr[d]} !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs dut%0d got=%b want=00000000", d, {rdy[d], cv[d], bm[d], cf[d], ch[d], pr[d]});
    end
    rst[d] = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (rdy[d] !== 1'b1 && n < 100);
    checks++;
    if (n !== 4 ** ORD[d]) begin
      errors++;
      $display("FAIL reset_clear_len dut%0d got=%0d want=%0d", d, n, 4 ** ORD[d]);
    end
    model_clear(d);
  endtask

  task automatic test_warmup_rock();
    obs_t o;
    int p, c;
    for (int i = 0; i < 4; i++) begin
      do_move(0, 0, -1, o);
      model_step(0, 0, o.rot, p, c);
      checks++;
      if ({o.timeout, o.cv1, o.rdy1, o.bm1, o.cv2, o.rdy2, o.bm2, o.cv3, o.rdy3} !== 9'b000010001) begin
        errors++;
        $display("FAIL rock_timing move%0d got=%b want=000010001", i,
                 {o.timeout, o.cv1, o.rdy1, o.bm1, o.cv2, o.rdy2, o.bm2, o.cv3, o.rdy3});
      end
      checks++;
      if ({o.pr, o.ch, o.cf} !== {2'(p), 2'((p + 1) % 3), 1'(c)}) begin
        errors++;
        $display("FAIL rock_model move%0d got pr=%0d ch=%0d cf=%0d want pr=%0d ch=%0d cf=%0d",
                 i, o.pr, o.ch, o.cf, p, (p + 1) % 3, c);
      end
      if (i == 0) begin
        checks++;
        if ({o.pr, o.cf} !== {2'(o.rot), 1'b0}) begin
          errors++;
          $display("FAIL rock_first got pr=%0d cf=%0d want pr=%0d cf=0", o.pr, o.cf, o.rot);
        end
      end
      if (i == 2) begin
        checks++;
        if ({o.pr, o.ch, o.cf} !== 5'b00_01_1) begin
          errors++;
          $display("FAIL rock_third got pr=%0d ch=%0d cf=%0d want pr=0 ch=1 cf=1", o.pr, o.ch, o.cf);
        end
      end
    end
  endtask

  task automatic test_tie();
    obs_t o;
    int p, c;
    int seq[3] = '{0, 0, 1};
    for (int pass = 0; pass < 2; pass++) begin
      test_reset(0);
      for (int i = 0; i < 3; i++) begin
        do_move(0, seq[i], -1, o);
        model_step(0, seq[i], o.rot, p, c);
      end
      do_move(0, 0, 1 - pass, o);
      model_step(0, 0, o.rot, p, c);
      checks++;
      if ({o.pr, o.ch, o.cf} !== ((pass == 0) ? 5'b01_10_0 : 5'b00_01_0)) begin
        errors++;
        $display("FAIL tie_rot%0d got pr=%0d ch=%0d cf=%0d rot=%0d", 1 - pass, o.pr, o.ch, o.cf, o.rot);
      end
    end
  endtask

  task automatic test_saturate();
    obs_t o;
    int p, c;
    int seq[11] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    for (int i = 0; i < 11; i++) begin
      do_move(2, seq[i], -1, o);
      model_step(2, seq[i], o.rot, p, c);
      checks++;
      if ({o.pr, o.cf} !== {2'(p), 1'(c)}) begin
        errors++;
        $display("FAIL sat_model step%0d got pr=%0d cf=%0d want pr=%0d cf=%0d", i, o.pr, o.cf, p, c);
      end
    end
    checks++;
    if ({o.pr, o.ch, o.cf} !== 5'b01_10_1) begin
      errors++;
      $display("FAIL sat_halved_row got pr=%0d ch=%0d cf=%0d want pr=1 ch=2 cf=1", o.pr, o.ch, o.cf);
    end
  endtask

  task automatic test_bad_move();
    obs_t o;
    int p, c;
    test_reset(0);
    do_move(0, 3, -1, o);
    checks++;
    if ({o.timeout, o.cv1, o.rdy1, o.bm1, o.cv2, o.bm2} !== 6'b001100) begin
      errors++;
      $display("FAIL bad_move_pulse got=%b want=001100", {o.timeout, o.cv1, o.rdy1, o.bm1, o.cv2, o.bm2});
    end
    for (int i = 0; i < 2; i++) begin
      do_move(0, 2, -1, o);
      model_step(0, 2, o.rot, p, c);
      checks++;
      if ({o.cv2, o.pr, o.cf} !== {1'b1, 2'(p), 1'(c)}) begin
        errors++;
        $display("FAIL bad_move_after%0d got cv=%0d pr=%0d cf=%0d want cv=1 pr=%0d cf=%0d",
                 i, o.cv2, o.pr, o.cf, p, c);
      end
    end
  endtask

  task automatic test_clear();
    obs_t o;
    int p, c;
    int n = 0;
    for (int i = 0; i < 3; i++) begin
      do_move(1, i, -1, o);
      model_step(1, i, o.rot, p, c);
    end
    clr[1] = 1'b1; mv[1] = 1'b1; mi[1] = 2'd0;
    @(negedge clk);
    clr[1] = 1'b0; mv[1] = 1'b0;
    checks++;
    if ({rdy[1], bm[1], cv[1]} !== 3'b000) begin
      errors++;
      $display("FAIL clear_blocks_move got rdy,bm,cv=%b want=000", {rdy[1], bm[1], cv[1]});
    end
    do begin
      @(negedge clk);
      n++;
    end while (rdy[1] !== 1'b1 && n < 100);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL clear_len got=%0d want=16", n);
    end
    model_clear(1);
    for (int i = 0; i < 2; i++) begin
      do_move(1, 1 - i, -1, o);
      model_step(1, 1 - i, o.rot, p, c);
      checks++;
      if ({o.cv2, o.pr, o.cf} !== {1'b1, 2'(o.rot), 1'b0}) begin
        errors++;
        $display("FAIL clear_warmup%0d got cv=%0d pr=%0d cf=%0d want cv=1 pr=%0d cf=0", i, o.cv2, o.pr, o.cf, o.rot);
      end
    end
  endtask

  task automatic test_reset_abort();
    obs_t o;
    int p, c;
    int n = 0;
    bit pulsed = 1'b0;
    mv[1] = 1'b1; mi[1] = 2'd1;
    @(posedge clk);
    @(negedge clk);
    mv[1] = 1'b0; rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    checks++;
    if ({cv[1], rdy[1]} !== 2'b00) begin
      errors++;
      $display("FAIL abort_no_pulse got cv,rdy=%b want=00", {cv[1], rdy[1]});
    end
    do begin
      @(negedge clk);
      n++;
      if (cv[1] === 1'b1) pulsed = 1'b1;
    end while (rdy[1] !== 1'b1 && n < 100);
    checks++;
    if (n !== 16 || pulsed) begin
      errors++;
      $display("FAIL abort_reclear got len=%0d pulse=%0d want len=16 pulse=0", n, pulsed);
    end
    model_clear(1);
    do_move(1, 2, -1, o);
    model_step(1, 2, o.rot, p, c);
    checks++;
    if ({o.pr, o.cf} !== {2'(p), 1'(c)}) begin
      errors++;
      $display("FAIL abort_next got pr=%0d cf=%0d want pr=%0d cf=%0d", o.pr, o.cf, p, c);
    end
  endtask

  task automatic test_random(input int d);
    obs_t o;
    int p, c, r, m;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = $urandom_range(0, 9);
      m = (r == 9) ? 3 : r % 3;
      do_move(d, m, -1, o);
      if (m == 3) begin
        checks++;
        if ({o.timeout, o.cv1, o.rdy1, o.bm1, o.cv2, o.bm2} !== 6'b001100) begin
          errors++;
          $display("FAIL rand_bad dut%0d step%0d got=%b want=001100", d, i,
                   {o.timeout, o.cv1, o.rdy1, o.bm1, o.cv2, o.bm2});
        end
      end else begin
        model_step(d, m, o.rot, p, c);
        checks++;
        if ({o.timeout, o.cv1, o.rdy1, o.bm1, o.cv2, o.rdy2, o.bm2, o.cv3, o.rdy3} !== 9'b000010001) begin
          errors++;
          $display("FAIL rand_timing dut%0d step%0d got=%b want=000010001", d, i,
                   {o.timeout, o.cv1, o.rdy1, o.bm1, o.cv2, o.rdy2, o.bm2, o.cv3, o.rdy3});
        end
        checks++;
        if ({o.pr, o.ch, o.cf} !== {2'(p), 2'((p + 1) % 3), 1'(c)}) begin
          errors++;
          $display("FAIL rand_model dut%0d step%0d got pr=%0d ch=%0d cf=%0d want pr=%0d ch=%0d cf=%0d",
                   d, i, o.pr, o.ch, o.cf, p, (p + 1) % 3, c);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; clr[d] = 1'b0; mv[d] = 1'b0; mi[d] = 2'd0;
    end
    for (int d = 0; d < 3; d++) test_reset(d);
    test_warmup_rock();
    test_tie();
    test_saturate();
    test_bad_move();
    test_clear();
    test_reset_abort();
    for (int d = 0; d < 3; d++) test_random(d);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
